// File: rtl/hpgp_turbo_interleaver_top.sv
// -----------------------------------------------------------------------------
// hpgp_turbo_interleaver_top
//
// Receive-side turbo (de)interleaver for the HPGP OFDM chain. One physical
// block of 2-bit soft symbols is captured in natural order. On command the
// block is read back in interleaved or deinterleaved order, four symbols per
// clock on four parallel lanes.
//
// Ports
//   clk           in   system clock, rising edge
//   n_rst         in   synchronous reset, active HIGH despite the name
//   pb_size[1:0]  in   0:PB16 (L=64) 1:PB136 (L=544) 2:PB520 (L=2080) 3:as 0
//   din[1:0]      in   input symbol
//   din_vld       in   frame-start strobe marking symbol 0
//   start         in   read-out command
//   mod_int_dint  in   0 = interleave, 1 = deinterleave
//   rdata0..3     out  lane outputs, zero whenever dout_vld is low
//   dout_vld      out  lane outputs valid
// -----------------------------------------------------------------------------
module hpgp_turbo_interleaver_top (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] pb_size,
   input  logic [1:0] din,
   input  logic       din_vld,
   input  logic       start,
   input  logic       mod_int_dint,
   output logic [1:0] rdata0,
   output logic [1:0] rdata1,
   output logic [1:0] rdata2,
   output logic [1:0] rdata3,
   output logic       dout_vld
);

   localparam int DEPTH = 2080;
   localparam int LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   // Block length L in symbols; reserved code 3 falls into the PB16 default.
   function automatic logic [11:0] blk_len(input logic [1:0] pb);
      case (pb)
         2'd1:    blk_len = 12'd544;
         2'd2:    blk_len = 12'd2080;
         default: blk_len = 12'd64;
      endcase
   endfunction

   // Address step: S for interleave, Sinv for deinterleave.
   function automatic logic [11:0] blk_step(input logic [1:0] pb, input logic dint);
      case ({pb, dint})
         3'b00_0: blk_step = 12'd7;
         3'b00_1: blk_step = 12'd55;
         3'b01_0: blk_step = 12'd19;
         3'b01_1: blk_step = 12'd315;
         3'b10_0: blk_step = 12'd31;
         3'b10_1: blk_step = 12'd671;
         3'b11_1: blk_step = 12'd55;
         default: blk_step = 12'd7;
      endcase
   endfunction

   // Lane start address (step*k*Q) mod L. Because L = 4Q this reduces to
   // ((step mod 4)*k mod 4)*Q, which needs only shifts and one add.
   function automatic logic [11:0] lane_start(input logic [1:0]  smod,
                                              input logic [1:0]  k,
                                              input logic [11:0] q);
      logic [3:0] prod;
      prod = {2'b00, smod} * {2'b00, k};
      case (prod[1:0])
         2'd0:    lane_start = 12'd0;
         2'd1:    lane_start = q;
         2'd2:    lane_start = q << 1;
         default: lane_start = (q << 1) + q;
      endcase
   endfunction

   // Incremental modulo: both operands are below L, so one conditional
   // subtraction wraps the sum. Largest sum 2079+671 fits in 12 bits.
   function automatic logic [11:0] addr_step(input logic [11:0] a,
                                             input logic [11:0] s,
                                             input logic [11:0] len);
      logic [11:0] sum;
      sum = a + s;
      addr_step = (sum >= len) ? (sum - len) : sum;
   endfunction

   logic [1:0]  mem [0:DEPTH-1];

   state_t      state_q;
   logic [1:0]  pb_q;
   logic        mode_q;
   logic [11:0] wr_addr_q;
   logic [11:0] rd_cnt_q;
   logic [11:0] addr_q  [LANES];
   logic [11:0] addr_d  [LANES];
   logic [1:0]  rdata_q [LANES];
   logic        dout_vld_q;

   logic [11:0] len_cur;
   logic [11:0] q_cur;
   logic [11:0] step_cur;
   logic [11:0] step_new;
   logic        wr_en;
   logic [11:0] wr_addr;

   always_comb begin
      len_cur  = blk_len(pb_q);
      q_cur    = len_cur >> 2;
      step_cur = blk_step(pb_q, mode_q);
      step_new = blk_step(pb_q, mod_int_dint);
      for (int k = 0; k < LANES; k++) begin
         addr_d[k] = addr_step(addr_q[k], step_cur, len_cur);
      end
   end

   // Symbol 0 lands in the same cycle as the strobe; WRITE fills 1..L-1.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = 12'd0;
      if (!n_rst) begin
         if (state_q == ST_IDLE && din_vld) begin
            wr_en   = 1'b1;
            wr_addr = 12'd0;
         end else if (state_q == ST_WRITE) begin
            wr_en   = 1'b1;
            wr_addr = wr_addr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q    <= ST_IDLE;
         pb_q       <= 2'd0;
         mode_q     <= 1'b0;
         wr_addr_q  <= 12'd0;
         rd_cnt_q   <= 12'd0;
         dout_vld_q <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            addr_q[k]  <= 12'd0;
            rdata_q[k] <= 2'd0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               dout_vld_q <= 1'b0;
               for (int k = 0; k < LANES; k++) begin
                  rdata_q[k] <= 2'd0;
               end
               // A frame strobe takes priority over a simultaneous start.
               if (din_vld) begin
                  pb_q      <= (pb_size == 2'd3) ? 2'd0 : pb_size;
                  wr_addr_q <= 12'd1;
                  state_q   <= ST_WRITE;
               end else if (start) begin
                  mode_q   <= mod_int_dint;
                  rd_cnt_q <= 12'd0;
                  for (int k = 0; k < LANES; k++) begin
                     addr_q[k] <= lane_start(step_new[1:0], 2'(k), q_cur);
                  end
                  state_q  <= ST_READ;
               end
            end

            ST_WRITE: begin
               dout_vld_q <= 1'b0;
               if (wr_addr_q == len_cur - 12'd1) begin
                  wr_addr_q <= 12'd0;
                  state_q   <= ST_IDLE;
               end else begin
                  wr_addr_q <= wr_addr_q + 12'd1;
               end
            end

            ST_READ: begin
               dout_vld_q <= 1'b1;
               for (int k = 0; k < LANES; k++) begin
                  rdata_q[k] <= mem[addr_q[k]];
                  addr_q[k]  <= addr_d[k];
               end
               if (rd_cnt_q == q_cur - 12'd1) begin
                  rd_cnt_q <= 12'd0;
                  state_q  <= ST_IDLE;
               end else begin
                  rd_cnt_q <= rd_cnt_q + 12'd1;
               end
            end

            default: begin
               dout_vld_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdata0   = rdata_q[0];
   assign rdata1   = rdata_q[1];
   assign rdata2   = rdata_q[2];
   assign rdata3   = rdata_q[3];
   assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_hpgp_turbo_interleaver_top.sv
// -----------------------------------------------------------------------------
// Testbench for hpgp_turbo_interleaver_top. Stimulus pushes expected lane
// words {rdata3,rdata2,rdata1,rdata0} into a queue; a negedge monitor pops
// and compares whenever dout_vld is high and checks zeroed outputs otherwise.
// -----------------------------------------------------------------------------
module tb_hpgp_turbo_interleaver_top;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [1:0] pb_size;
   logic [1:0] din;
   logic       din_vld;
   logic       start;
   logic       mod_int_dint;
   logic [1:0] rdata0, rdata1, rdata2, rdata3;
   logic       dout_vld;

   always #5 clk = ~clk;

   hpgp_turbo_interleaver_top dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .pb_size      (pb_size),
      .din          (din),
      .din_vld      (din_vld),
      .start        (start),
      .mod_int_dint (mod_int_dint),
      .rdata0       (rdata0),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .rdata3       (rdata3),
      .dout_vld     (dout_vld)
   );

   logic [1:0] mdl_mem [0:2079];
   logic [7:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         vld_cnt = 0;
   logic [7:0] cap0 = 8'h00;
   logic [7:0] cap1 = 8'h00;
   bit         mon_en = 1'b0;

   function automatic int len_of(input logic [1:0] pb);
      case (pb)
         2'd1:    len_of = 544;
         2'd2:    len_of = 2080;
         default: len_of = 64;
      endcase
   endfunction

   function automatic int step_of(input logic [1:0] pb, input logic dint);
      case (pb)
         2'd1:    step_of = dint ? 315 : 19;
         2'd2:    step_of = dint ? 671 : 31;
         default: step_of = dint ? 55 : 7;
      endcase
   endfunction

   // kind 0: PB16 directed pattern; kind 1: ramp i mod 4.
   function automatic logic [1:0] gen_sym(input int kind, input int i);
      if (kind == 1)      gen_sym = 2'(i % 4);
      else if (i == 0)    gen_sym = 2'b00;
      else if (i <= 48)   gen_sym = (i % 2 == 1) ? 2'b01 : 2'b10;
      else                gen_sym = (i % 2 == 1) ? 2'b00 : 2'b11;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      logic [7:0] act;
      logic [7:0] expv;
      if (mon_en) begin
         act = {rdata3, rdata2, rdata1, rdata0};
         if (dout_vld === 1'b1) begin
            if (vld_cnt == 0) cap0 = act;
            if (vld_cnt == 1) cap1 = act;
            vld_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out act=%h exp=none", act);
            end else begin
               expv = exp_q.pop_front();
               if (act !== expv) begin
                  errors++;
                  $display("FAIL lane_data j=%0d act=%h exp=%h", vld_cnt - 1, act, expv);
               end
            end
         end else begin
            checks++;
            if (dout_vld !== 1'b0 || act !== 8'h00) begin
               errors++;
               $display("FAIL idle_out act_vld=%b act=%h exp_vld=0 exp=00", dout_vld, act);
            end
         end
      end
   end

   task automatic write_block(input logic [1:0] pb, input int kind, input bit pulse_start);
      int L;
      L = len_of(pb);
      for (int i = 0; i < L; i++) begin
         mdl_mem[i] = gen_sym(kind, i);
         din        = mdl_mem[i];
         din_vld    = (i == 0);
         pb_size    = pb;
         start      = (pulse_start && i == L / 2);
         tick();
      end
      din_vld = 1'b0;
      start   = 1'b0;
   endtask

   task automatic read_block(input logic [1:0] pb, input logic mode, input bit pulse_din);
      int L, Q, S, n, a;
      logic [7:0] w;
      L = len_of(pb);
      Q = L / 4;
      S = step_of(pb, mode);
      for (int j = 0; j < Q; j++) begin
         for (int k = 0; k < 4; k++) begin
            n = j + k * Q;
            a = (S * n) % L;
            w[2*k +: 2] = mdl_mem[a];
         end
         exp_q.push_back(w);
      end
      vld_cnt      = 0;
      mod_int_dint = mode;
      start        = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < Q + 4; c++) begin
         din_vld = (pulse_din && c == 2);
         din     = 2'b11;
         tick();
      end
      din_vld = 1'b0;
      chk("queue_drained", exp_q.size(), 0);
      chk("vld_cycles", vld_cnt, Q);
      exp_q.delete();
   endtask

   initial begin
      n_rst        = 1'b1;
      pb_size      = 2'd0;
      din          = 2'b00;
      din_vld      = 1'b0;
      start        = 1'b1;
      mod_int_dint = 1'b0;
      tick();
      tick();
      mon_en = 1'b1;
      chk("reset_vld", int'(dout_vld), 0);
      chk("reset_data", int'({rdata3, rdata2, rdata1, rdata0}), 0);
      start = 1'b0;
      n_rst = 1'b0;
      repeat (4) tick();
      chk("reset_no_readout", vld_cnt, 0);

      // PB16 directed pattern, deinterleave then interleave replay
      write_block(2'd0, 0, 1'b0);
      read_block(2'd0, 1'b1, 1'b0);
      chk("pb16_dint_j0", int'(cap0), 8'hA8);
      chk("pb16_dint_j1_l01", int'(cap1[3:0]), 4'b0100);
      read_block(2'd0, 1'b0, 1'b0);
      chk("pb16_int_j0", int'(cap0), 8'hA8);
      chk("pb16_int_j1_l0", int'(cap1[1:0]), 1);

      // PB136 ramp with ignored start during write and din_vld during read
      write_block(2'd1, 1, 1'b1);
      read_block(2'd1, 1'b0, 1'b1);
      chk("pb136_int_j1_l0", int'(cap1[1:0]), 3);
      read_block(2'd1, 1'b1, 1'b0);

      // PB520 ramp
      write_block(2'd2, 1, 1'b0);
      read_block(2'd2, 1'b0, 1'b0);
      chk("pb520_int_j1_l0", int'(cap1[1:0]), 3);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hpgp_turbo_interleaver_top.md
# hpgp_turbo_interleaver_top

Receive-side turbo (de)interleaver for the HPGP OFDM chain. It captures one physical block (PB) of 2-bit soft-symbol pairs into internal storage in natural order. On command it reads the block back in interleaved or deinterleaved order, four symbols per clock on four parallel lanes, for the downstream turbo decoder.

## Interface
- No parameters. Block sizes are fixed by `pb_size`.
- `clk` in 1: single system clock, rising edge.
- `n_rst` in 1: synchronous, active-high reset. A value of 1 on a rising `clk` edge resets the block.
- `pb_size` in 2: block length L, in 2-bit symbols. 0 = PB16 (L=64). 1 = PB136 (L=544). 2 = PB520 (L=2080). 3 is reserved and treated as 0.
- `din` in 2: input symbol.
- `din_vld` in 1: one-cycle frame-start strobe that marks symbol 0.
- `start` in 1: one-cycle read-out command.
- `mod_int_dint` in 1: read order. 0 = interleave, 1 = deinterleave.
- `rdata0..rdata3` out 2 each: lane outputs.
- `dout_vld` out 1: lane outputs are valid.

## Operation
- States:
  - IDLE
  - WRITE
  - READ
- Storage is 2080 × 2 bits, with one write port and four read ports. Flop or multi-port array is acceptable.
- **IDLE → WRITE** on `din_vld`=1:
  - Latch `pb_size`, which sets L.
  - Write `din` of that same cycle to address 0.
- **WRITE** stores `din` at addresses 1..L-1 on the following L-1 consecutive cycles, regardless of `din_vld`.
  - After address L-1 is written, return to IDLE.
  - `din_vld` and `start` are ignored while in WRITE.
- **IDLE → READ** on `start`=1. Latch `mod_int_dint`. `start` while in READ or WRITE is ignored.
- **READ** lasts Q = L/4 cycles, indexed j = 0..Q-1. Lane k outputs logical index n = j + k·Q:
  - interleave: `rdata_k` = mem[(S·n) mod L]
  - deinterleave: `rdata_k` = mem[(Sinv·n) mod L]
- Step constants:
  - PB16: S=7, Sinv=55.
  - PB136: S=19, Sinv=315.
  - PB520: S=31, Sinv=671.
- Address generation uses no multiplier:
  - Each lane address starts at (step·k·Q) mod L, which equals ((step mod 4)·k·Q) mod L.
  - Each cycle, addr ← addr + step, minus L if the result is ≥ L.
  - Do the modulo compare at 12-bit width.
- After the last read cycle, return to IDLE. The stored data is retained, so a new `start` replays the block, possibly in the other mode.
- A reset during WRITE or READ aborts the operation. Storage contents need not be cleared.

## Timing
- Reset values: `rdata0..3`=0, `dout_vld`=0, state IDLE, counters 0.
- Write latency: symbol i is stored at the edge i cycles after the `din_vld` edge.
- Read latency: `start` is sampled at edge T. `dout_vld`=1 and lane data for j=0 are registered at edge T+1. j advances by one each cycle, so `dout_vld` stays high for exactly Q cycles.
- Outputs are registered. `rdata*` is driven to 0 whenever `dout_vld`=0.
- If `din_vld` and `start` are asserted in the same IDLE cycle, `din_vld` wins and `start` is dropped.

## Test plan
- **Reset:** hold `n_rst`=1 for 2 cycles → all outputs 0, `dout_vld`=0. Assert `start` during reset → no read-out.
- **PB16 deinterleave:**
  - Stimulus: `pb_size`=0, `din_vld` pulse with `din`=00. Then 48 symbols alternating 01, 10 (odd index 01, even 10). Then 15 symbols alternating 00, 11 (index 49 = 00). Then `mod_int_dint`=1 and a `start` pulse.
  - Response: 16 valid cycles.
  - j=0 → rdata0..3 = 00, 10, 10, 10 (addresses 0, 48, 32, 16).
  - j=1 → rdata0 = mem[55] = 00, rdata1 = mem[39] = 01.
- **PB16 interleave, same data:** j=0 addresses 0, 48, 32, 16. j=1 → lane 0 reads mem[7] = 01. `dout_vld` drops after exactly 16 cycles.
- **PB136 and PB520 ramp fill:**
  - Stimulus: symbol i = i mod 4.
  - Interleave: lane 0 at j=1 reads address 19 (PB136) or 31 (PB520).
  - `dout_vld` is high for 136 or 520 cycles respectively.
- **Ignore rules:** pulse `start` during WRITE, and `din_vld` during READ → no state change, and the read-out matches a clean run.
- **Replay:** two `start` pulses after one write, first in mode 0 then mode 1 → both sequences are correct.
